// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: drives J/K of a JK flop bank toward a target word, then verifies and retries.
// Optional JK_TOGGLE_EN: changed bits use the 11 (toggle) drive instead of set/reset.
module jk_excite_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);
  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] MAXR = CW'(MAX_RETRY);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d, mask_q, mask_d, src, j_x, k_x;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  // In IDLE the excitation is computed from the incoming word, afterwards from the latched target
  assign src = (state_q == IDLE) ? tgt_data : tgt_q;
`ifdef JK_TOGGLE_EN
  assign j_x = q_fb ^ src;
  assign k_x = q_fb ^ src;
`else
  assign j_x = ~q_fb & src;
  assign k_x = q_fb & ~src;
`endif
  assign tgt_ready = (state_q == IDLE);
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (tgt_valid) begin
        tgt_d   = tgt_data;
        mask_d  = '0;
        cnt_d   = '0;
        j_d     = j_x;
        k_d     = k_x;
        state_d = DRIVE;
      end
      DRIVE: state_d = CHECK;
      CHECK: if (q_fb == tgt_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (cnt_q < MAXR) begin
        cnt_d   = cnt_q + 1'b1;
        j_d     = j_x;
        k_d     = k_x;
        state_d = DRIVE;
      end else begin
        err_d   = 1'b1;
        mask_d  = q_fb ^ tgt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule
